seq_mult_param: RTL and testbench

//  Parametrised sequential shift-add multiplier; next generation of the team's 8x8 FSM multiplier.

---
 rtl/seq_mult_param_if.sv | 23 ++
 rtl/seq_mult_param.sv | 116 +++++++++++
 tb/tb_seq_mult_param.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_param_if.sv
// Operand/result bundle between an operand producer and the sequential multiplier.
// The producer drives the operands; the multiplier returns the product, its strobe and a busy flag.
interface seq_mult_param_if #(
  parameter int WIDTH = 8
);
  logic               in_en;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] prdct;
  logic               out_en;
  logic               busy;

  modport master (
    output in_en, signed_mode, a, b,
    input  prdct, out_en, busy
  );

  modport slave (
    input  in_en, signed_mode, a, b,
    output prdct, out_en, busy
  );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier: one adder, one multiplier bit per clock.
// Signed operands are multiplied as magnitudes and the sign is applied in a final step.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_mult_param_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH:0]     mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [PW-1:0]      acc_reg, acc_next;
  logic [PW-1:0]      prdct_reg, prdct_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               neg_reg, neg_next;
  logic               out_en_reg, out_en_next;
  logic               busy_reg, busy_next;

  logic [WIDTH:0]     a_ext, b_ext;
  logic [WIDTH:0]     a_mag, b_mag;
  logic [PW-1:0]      addend;

  // Sign-extend by one bit so the most-negative value has a representable magnitude.
  always_comb begin
    a_ext = {bus.signed_mode & bus.a[WIDTH-1], bus.a};
    b_ext = {bus.signed_mode & bus.b[WIDTH-1], bus.b};
    a_mag = a_ext[WIDTH] ? (~a_ext + 1'b1) : a_ext;
    b_mag = b_ext[WIDTH] ? (~b_ext + 1'b1) : b_ext;
  end

  assign addend = {{(WIDTH-1){1'b0}}, mcand_reg} << cnt_reg;

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    prdct_next  = prdct_reg;
    cnt_next    = cnt_reg;
    neg_next    = neg_reg;
    out_en_next = 1'b0;
    busy_next   = busy_reg;

    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.in_en) begin
          // Multiplier magnitude never exceeds 2^(WIDTH-1) or 2^WIDTH-1, so WIDTH bits suffice.
          mcand_next  = a_mag;
          mplier_next = b_mag[WIDTH-1:0];
          neg_next    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_next    = '0;
          cnt_next    = '0;
          busy_next   = 1'b1;
          state_next  = CALC;
        end
      end

      CALC: begin
        if (mplier_reg[cnt_reg]) begin
          acc_next = acc_reg + addend;
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end

      FIX: begin
        prdct_next  = neg_reg ? (~acc_reg + 1'b1) : acc_reg;
        out_en_next = 1'b1;
        busy_next   = 1'b0;
        state_next  = DONE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      prdct_reg  <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      out_en_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      prdct_reg  <= prdct_next;
      cnt_reg    <= cnt_next;
      neg_reg    <= neg_next;
      out_en_reg <= out_en_next;
      busy_reg   <= busy_next;
    end
  end

  assign bus.prdct  = prdct_reg;
  assign bus.out_en = out_en_reg;
  assign bus.busy   = busy_reg;
endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: 8-bit and 16-bit instances, scoreboard queue of expected products.
// Latency is measured in rising edges from the accept edge to the edge that raises out_en.
module tb_seq_mult_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_mult_param_if #(.WIDTH(8))  bus8();
  seq_mult_param_if #(.WIDTH(16)) bus16();

  seq_mult_param #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_mult_param #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;
  logic [15:0] exp8_q[$];
  logic [31:0] exp16_q[$];

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    logic signed [15:0] sa, sb;
    logic [15:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {8'h00, a};
    ub = {8'h00, b};
    return sm ? 16'(sa * sb) : 16'(ua * ub);
  endfunction

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] exp, input bit now, output int acc_edge);
    if (!now) @(negedge clk);
    bus8.a = a;
    bus8.b = b;
    bus8.signed_mode = sm;
    bus8.in_en = 1'b1;
    acc_edge = ecnt + 1;
    exp8_q.push_back(exp);
  endtask

  // Waits for out_en only; operands are scrambled each cycle to show they need not be held.
  task automatic wait8(input int budget, output int edge_at, output int busy_cyc, output bit to);
    to = 1'b1;
    busy_cyc = 0;
    edge_at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      bus8.in_en = 1'b0;
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      bus8.signed_mode = 1'($urandom);
      if (bus8.busy === 1'b1) busy_cyc++;
      if (bus8.out_en === 1'b1) begin
        edge_at = ecnt;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.in_en = 1'b0; bus8.a = '0; bus8.b = '0; bus8.signed_mode = 1'b0;
    bus16.in_en = 1'b0; bus16.a = '0; bus16.b = '0; bus16.signed_mode = 1'b0;
    #70;
    @(negedge clk);
    n_vec++;
    if (bus8.prdct !== 16'h0000) begin
      $display("FAIL reset_prdct got %h want 0000", bus8.prdct); n_err++;
    end
    n_vec++;
    if (bus8.out_en !== 1'b0) begin
      $display("FAIL reset_out_en got %b want 0", bus8.out_en); n_err++;
    end
    n_vec++;
    if (bus8.busy !== 1'b0) begin
      $display("FAIL reset_busy got %b want 0", bus8.busy); n_err++;
    end
    n_vec++;
    if (bus16.prdct !== 32'h0 || bus16.busy !== 1'b0 || bus16.out_en !== 1'b0) begin
      $display("FAIL reset_w16 got prdct=%h busy=%b out_en=%b want 0/0/0",
               bus16.prdct, bus16.busy, bus16.out_en); n_err++;
    end
    $display("reset: prdct=%h out_en=%b busy=%b", bus8.prdct, bus8.out_en, bus8.busy);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int acc, e, bc;
    bit to;
    logic [15:0] exp;
    issue8(8'd5, 8'd5, 1'b0, 16'd25, 1'b0, acc);
    wait8(40, e, bc, to);
    exp = exp8_q.pop_front();
    n_vec++;
    if (to) begin
      $display("FAIL basic_timeout got no out_en want out_en"); n_err++;
    end else begin
      if (e - acc != 9 || bus8.prdct !== exp || bc != 9) begin
        $display("FAIL basic_5x5 got prdct=%h lat=%0d busy=%0d want %h/9/9", bus8.prdct, e - acc, bc, exp);
        n_err++;
      end
      $display("basic: 5*5 prdct=%h lat=%0d busy_cycles=%0d", bus8.prdct, e - acc, bc);
    end
  endtask

  task automatic test_modes();
    logic [7:0]  ta [0:6] = '{8'hFF, 8'hFF, 8'hFD, 8'h80, 8'h80, 8'h00, 8'h00};
    logic [7:0]  tb [0:6] = '{8'hFF, 8'hFF, 8'h05, 8'h80, 8'h7F, 8'hC8, 8'hFB};
    logic        ts [0:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] te [0:6] = '{16'hFE01, 16'h0001, 16'hFFF1, 16'h4000, 16'hC080, 16'h0000, 16'h0000};
    int acc, e, bc;
    bit to;
    logic [15:0] exp;
    for (int k = 0; k < 7; k++) begin
      issue8(ta[k], tb[k], ts[k], te[k], 1'b0, acc);
      wait8(40, e, bc, to);
      exp = exp8_q.pop_front();
      n_vec++;
      if (to) begin
        $display("FAIL mode_timeout[%0d] got no out_en want out_en", k); n_err++;
      end else begin
        if (bus8.prdct !== exp || e - acc != 9) begin
          $display("FAIL mode[%0d] got prdct=%h lat=%0d want %h/9", k, bus8.prdct, e - acc, exp);
          n_err++;
        end
        $display("mode: a=%h b=%h s=%b prdct=%h lat=%0d", ta[k], tb[k], ts[k], bus8.prdct, e - acc);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int acc, e, bc, extra;
    bit to;
    logic [15:0] exp;
    issue8(8'd5, 8'd5, 1'b0, 16'd25, 1'b0, acc);
    @(negedge clk);
    bus8.in_en = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus8.busy !== 1'b1) begin
      $display("FAIL ignore_busy_flag got %b want 1", bus8.busy); n_err++;
    end
    bus8.a = 8'd7; bus8.b = 8'd9; bus8.signed_mode = 1'b0; bus8.in_en = 1'b1;
    wait8(40, e, bc, to);
    exp = exp8_q.pop_front();
    n_vec++;
    if (to) begin
      $display("FAIL ignore_timeout got no out_en want out_en"); n_err++;
    end else if (bus8.prdct !== exp || e - acc != 9) begin
      $display("FAIL ignore_result got prdct=%h lat=%0d want %h/9", bus8.prdct, e - acc, exp); n_err++;
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus8.out_en === 1'b1) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      $display("FAIL ignore_extra_out_en got %0d want 0", extra); n_err++;
    end
    $display("ignore: prdct=%h extra_pulses=%0d", bus8.prdct, extra);
  endtask

  task automatic test_back_to_back();
    int acc, e1, e2, bc;
    bit to;
    logic [15:0] exp;
    logic [7:0] ra, rb;
    logic rs;
    issue8(8'd6, 8'd7, 1'b0, 16'd42, 1'b0, acc);
    wait8(40, e1, bc, to);
    exp = exp8_q.pop_front();
    n_vec++;
    if (to || bus8.prdct !== exp) begin
      $display("FAIL b2b_first got prdct=%h to=%b want %h", bus8.prdct, to, exp); n_err++;
    end
    issue8(8'd3, 8'd4, 1'b0, 16'd12, 1'b1, acc);
    for (int k = 0; k < 21; k++) begin
      wait8(40, e2, bc, to);
      exp = exp8_q.pop_front();
      n_vec++;
      if (to) begin
        $display("FAIL b2b_timeout[%0d] got no out_en want out_en", k); n_err++;
        break;
      end
      if (bus8.prdct !== exp || e2 - e1 != 10) begin
        $display("FAIL b2b[%0d] got prdct=%h gap=%0d want %h/10", k, bus8.prdct, e2 - e1, exp); n_err++;
      end
      $display("b2b[%0d]: prdct=%h gap=%0d", k, bus8.prdct, e2 - e1);
      e1 = e2;
      if (k < 20) begin
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
        issue8(ra, rb, rs, model8(ra, rb, rs), 1'b1, acc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, e, bc, seen;
    bit to;
    logic [15:0] exp;
    issue8(8'd11, 8'd13, 1'b0, 16'd143, 1'b0, acc);
    void'(exp8_q.pop_back());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus8.in_en = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (bus8.prdct !== 16'h0000 || bus8.busy !== 1'b0 || bus8.out_en !== 1'b0) begin
      $display("FAIL abort_state got prdct=%h busy=%b out_en=%b want 0000/0/0",
               bus8.prdct, bus8.busy, bus8.out_en); n_err++;
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.out_en === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      $display("FAIL abort_out_en got %0d pulses want 0", seen); n_err++;
    end
    issue8(8'd9, 8'd9, 1'b0, 16'd81, 1'b0, acc);
    wait8(40, e, bc, to);
    exp = exp8_q.pop_front();
    n_vec++;
    if (to || bus8.prdct !== exp || e - acc != 9) begin
      $display("FAIL abort_recover got prdct=%h lat=%0d to=%b want %h/9", bus8.prdct, e - acc, to, exp);
      n_err++;
    end
    $display("abort: pulses=%0d recover prdct=%h", seen, bus8.prdct);
  endtask

  task automatic test_w16();
    logic [15:0] wa [0:2] = '{16'hFFFF, 16'h8000, 16'hFFFF};
    logic [15:0] wb [0:2] = '{16'hFFFF, 16'h8000, 16'h0003};
    logic        ws [0:2] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] we [0:2] = '{32'hFFFE0001, 32'h40000000, 32'hFFFFFFFD};
    int acc, e;
    bit to;
    logic [31:0] exp;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus16.a = wa[k]; bus16.b = wb[k]; bus16.signed_mode = ws[k]; bus16.in_en = 1'b1;
      acc = ecnt + 1;
      exp16_q.push_back(we[k]);
      to = 1'b1;
      e = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        bus16.in_en = 1'b0;
        if (bus16.out_en === 1'b1) begin
          e = ecnt; to = 1'b0; break;
        end
      end
      exp = exp16_q.pop_front();
      n_vec++;
      if (to) begin
        $display("FAIL w16_timeout[%0d] got no out_en want out_en", k); n_err++;
      end else begin
        if (bus16.prdct !== exp || e - acc != 17) begin
          $display("FAIL w16[%0d] got prdct=%h lat=%0d want %h/17", k, bus16.prdct, e - acc, exp);
          n_err++;
        end
        $display("w16: a=%h b=%h s=%b prdct=%h lat=%0d", wa[k], wb[k], ws[k], bus16.prdct, e - acc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_w16();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
